// File: rtl/coord_mover_pkg.sv
// coord_mover_pkg: shared constants and helpers for the coordinate mover.
// Holds the boundary-mode encodings, the default screen bounds for the
// vertical axis, and a clamp helper used when loading an absolute position.
package coord_mover_pkg;

   // Boundary behaviour encodings
   localparam logic [1:0] MODE_SAT    = 2'd0;
   localparam logic [1:0] MODE_WRAP   = 2'd1;
   localparam logic [1:0] MODE_BOUNCE = 2'd2;

   // Visible area limits for the vertical axis
   localparam int SCREEN_MIN_Y = 18;
   localparam int SCREEN_MAX_Y = 487;

   // Widest coordinate the clamp helper handles; callers zero-extend into it
   localparam int CLAMP_W = 64;

   // Clamp v into [lo, hi]; assumes lo <= hi
   function automatic logic [CLAMP_W-1:0] clamp_pos(
      input logic [CLAMP_W-1:0] v,
      input logic [CLAMP_W-1:0] lo,
      input logic [CLAMP_W-1:0] hi
   );
      logic [CLAMP_W-1:0] r;
      r = v;
      if (v < lo) begin
         r = lo;
      end else if (v > hi) begin
         r = hi;
      end
      return r;
   endfunction

endpackage

// File: rtl/coord_next_calc.sv
// coord_next_calc: purely combinational next-position / next-direction logic.
// Given the current registered coordinate, direction and effective step, it
// produces the result of one tick-move for the configured boundary mode.
// All add/subtract compares are done one bit wider than the coordinate so a
// move can never wrap through 0 or 2^WIDTH unnoticed.
module coord_next_calc
   import coord_mover_pkg::*;
#(
   parameter int         WIDTH   = 16,
   parameter int         MIN_POS = SCREEN_MIN_Y,
   parameter int         MAX_POS = SCREEN_MAX_Y,
   parameter logic [1:0] MODE    = MODE_SAT
) (
   input  logic [WIDTH-1:0] pos,
   input  logic             dir,
   input  logic [WIDTH-1:0] step,
   input  logic             up,
   input  logic             dw,
   output logic [WIDTH-1:0] next_pos,
   output logic             next_dir
);

   localparam logic [WIDTH:0]   MIN_X = (WIDTH+1)'(MIN_POS);
   localparam logic [WIDTH:0]   MAX_X = (WIDTH+1)'(MAX_POS);
   localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_POS);
   localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_POS);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   floor_x;
   logic [WIDTH-1:0] diff;
   logic             past_max;
   logic             hit_max;
   logic             past_min;
   logic             hit_min;
   logic             move_up;

   // Bound comparisons shared by all modes
   always_comb begin
      sum      = {1'b0, pos} + {1'b0, step};
      floor_x  = MIN_X + {1'b0, step};
      diff     = pos - step;
      past_max = (sum > MAX_X);
      hit_max  = (sum >= MAX_X);
      past_min = ({1'b0, pos} < floor_x);
      hit_min  = ({1'b0, pos} <= floor_x);
   end

   // Mode-specific move selection
   always_comb begin
      next_pos = pos;
      next_dir = dir;
      move_up  = dir;
      if (MODE == MODE_BOUNCE) begin
         // Buttons steer; with both or neither pressed, keep going
         if (up && !dw) begin
            move_up = 1'b1;
         end else if (dw && !up) begin
            move_up = 1'b0;
         end
         // Sitting on a bound always moves away from it
         if (pos == MAX_W && move_up) begin
            move_up = 1'b0;
         end else if (pos == MIN_W && !move_up) begin
            move_up = 1'b1;
         end
         if (move_up) begin
            if (hit_max) begin
               next_pos = MAX_W;
               next_dir = 1'b0;
            end else begin
               next_pos = sum[WIDTH-1:0];
               next_dir = 1'b1;
            end
         end else begin
            if (hit_min) begin
               next_pos = MIN_W;
               next_dir = 1'b1;
            end else begin
               next_pos = diff;
               next_dir = 1'b0;
            end
         end
      end else begin
         if (up && !dw) begin
            next_dir = 1'b1;
            if (past_max) begin
               next_pos = (MODE == MODE_WRAP) ? MIN_W : MAX_W;
            end else begin
               next_pos = sum[WIDTH-1:0];
            end
         end else if (dw && !up) begin
            next_dir = 1'b0;
            if (past_min) begin
               next_pos = (MODE == MODE_WRAP) ? MAX_W : MIN_W;
            end else begin
               next_pos = diff;
            end
         end
      end
   end

endmodule

// File: rtl/coord_mover.sv
// coord_mover: one on-screen coordinate axis moved by frame ticks.
// Registers the coordinate and direction, applies reset > load > tick-move
// priority, and derives the boundary flags from the registered position.
// Optional hold acceleration is built only when COORD_MOVER_ACCEL_EN is
// defined; otherwise the step is the constant STEP and no extra state exists.
// Loads are clamped through a 64-bit helper, so WIDTH is limited to 64.
module coord_mover
   import coord_mover_pkg::*;
#(
   parameter int         WIDTH     = 16,
   parameter int         MIN_POS   = SCREEN_MIN_Y,
   parameter int         MAX_POS   = SCREEN_MAX_Y,
   parameter int         RESET_POS = SCREEN_MIN_Y,
   parameter int         STEP      = 1,
   parameter logic [1:0] MODE      = MODE_SAT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             UP,
   input  logic             DW,
   input  logic             LD,
   input  logic [WIDTH-1:0] ld_val,
   output logic [WIDTH-1:0] pos,
   output logic             at_max,
   output logic             at_min,
   output logic             dir_up
);

   localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_POS);
   localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_POS);
   localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_POS);

   logic [WIDTH-1:0] step_eff;
   logic [WIDTH-1:0] next_pos;
   logic             next_dir;
   logic [WIDTH-1:0] ld_clamped;

`ifdef COORD_MOVER_ACCEL_EN
   // Shifted step is kept wide and capped at the span; any larger step lands
   // on or beyond a bound from every legal position, so results are unchanged.
   localparam logic [WIDTH+2:0] SPAN_X   = (WIDTH+3)'(MAX_POS - MIN_POS);
   localparam logic             ACCEL_OK = (MODE != MODE_BOUNCE);

   logic [2:0]       hold_cnt;
   logic [1:0]       level;
   logic             single;
   logic             same_dir;
   logic [1:0]       eff_level;
   logic [WIDTH+2:0] step_shift;

   // Acceleration applies only while the held button matches the current run
   always_comb begin
      single     = UP ^ DW;
      same_dir   = (UP && dir_up) || (DW && !dir_up);
      eff_level  = (ACCEL_OK && single && same_dir) ? level : 2'd0;
      step_shift = (WIDTH+3)'(STEP) << eff_level;
      step_eff   = (step_shift > SPAN_X) ? SPAN_X[WIDTH-1:0]
                                         : step_shift[WIDTH-1:0];
   end

   // Hold counter and level; a new run counts its first tick as 1
   always_ff @(posedge clk) begin
      if (reset || LD || !single || !ACCEL_OK) begin
         hold_cnt <= 3'd0;
         level    <= 2'd0;
      end else if (tick) begin
         if (!same_dir) begin
            hold_cnt <= 3'd1;
            level    <= 2'd0;
         end else begin
            hold_cnt <= hold_cnt + 3'd1;
            if (hold_cnt == 3'd7 && level != 2'd2) begin
               level <= level + 2'd1;
            end
         end
      end
   end
`else
   // Fixed step
   always_comb begin
      step_eff = WIDTH'(STEP);
   end
`endif

   coord_next_calc #(
      .WIDTH   (WIDTH),
      .MIN_POS (MIN_POS),
      .MAX_POS (MAX_POS),
      .MODE    (MODE)
   ) u_calc (
      .pos      (pos),
      .dir      (dir_up),
      .step     (step_eff),
      .up       (UP),
      .dw       (DW),
      .next_pos (next_pos),
      .next_dir (next_dir)
   );

   // Load value forced into the legal range
   always_comb begin
      ld_clamped = WIDTH'(clamp_pos(CLAMP_W'(ld_val), CLAMP_W'(MIN_POS),
                                    CLAMP_W'(MAX_POS)));
   end

   // Coordinate and direction registers: reset > load > tick-move > hold
   always_ff @(posedge clk) begin
      if (reset) begin
         pos    <= RESET_W;
         dir_up <= 1'b1;
      end else if (LD) begin
         pos <= ld_clamped;
      end else if (tick) begin
         pos    <= next_pos;
         dir_up <= next_dir;
      end
   end

   // Boundary flags from the registered coordinate
   always_comb begin
      at_max = (pos == MAX_W);
      at_min = (pos == MIN_W);
   end

endmodule
